// File: rtl/cru_pkg.sv
// Shared constants for the CRU-mapped interrupt controller: bus status code,
// bit offsets of the mask and pending fields, and the CRU window geometry.
package cru_pkg;

   // Bus status presented by the CPU during an interrupt-acknowledge cycle
   localparam logic [3:0] BST_INTA  = 4'b0101;

   // Bit offsets of the mask and pending fields inside the CRU window
   localparam int         MASK_OFS  = 0;
   localparam int         PEND_OFS  = 8;

   // Number of CRU bits in one window (also the width of the flag register)
   localparam int         CRU_WIN_W = 16;

   // Window bits taken over by the interrupt map; these never appear on flag
   function automatic logic [CRU_WIN_W-1:0] map_bits(input int nsrc);
      logic [CRU_WIN_W-1:0] m;
      m = '0;
      for (int k = 0; k < nsrc; k++) begin
         m[MASK_OFS + k] = 1'b1;
         m[PEND_OFS + k] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/prio_enc.sv
// Lowest-index-wins priority encoder for up to eight request lines.
module prio_enc #(
   parameter int N = 2
) (
   input  logic [N-1:0] req,
   output logic         valid,
   output logic [2:0]   idx
);

   // Scan from the top down so the lowest set bit is the last one written
   always_comb begin
      valid = |req;
      idx   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req[k]) idx = 3'(k);
      end
   end

endmodule

// File: rtl/cru_irq_ctrl.sv
// CRU-mapped interrupt controller and general flag register.
// NSRC sources, each with a mask bit, a pending latch (edge or level mode,
// software set/clear, cleared by INTA at its level), arbitrated lowest index
// first into a registered request and level code for the CPU.
module cru_irq_ctrl
   import cru_pkg::*;
#(
   parameter int         NSRC      = 2,
   parameter logic [10:0] BASE     = 11'h0F7,
   parameter logic [3:0] LVL0      = 4'd1,
   parameter logic [7:0] EDGE_MASK = 8'h01
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [15:0]          cab,
   input  logic [3:0]           bst,
   input  logic                 cruclk,
   input  logic                 cruout,
   input  logic [NSRC-1:0]      src,
   output logic                 sel,
   output logic                 cruin,
   output logic                 int_req,
   output logic [3:0]           ic,
   output logic [CRU_WIN_W-1:0] flag
);

   localparam logic [CRU_WIN_W-1:0] MAP_BITS = map_bits(NSRC);

   logic [3:0]           cru_bit;
   logic                 cruclk_d;
   logic                 wr_stb;
   logic                 is_inta;
   logic [NSRC-1:0]      src_d;
   logic [NSRC-1:0]      mask_q;
   logic [NSRC-1:0]      pend_q;
   logic [NSRC-1:0]      pend_set;
   logic [NSRC-1:0]      pend_clr;
   logic [NSRC-1:0]      active;
   logic [CRU_WIN_W-1:0] flag_q;
   logic                 act_vld;
   logic [2:0]           act_idx;
   logic                 rd_bit;
   logic                 unused_cab0;

   // cab[0] is not part of the CRU bit address
   assign unused_cab0 = cab[0];

   assign cru_bit = cab[4:1];
   assign sel     = (cab[15:5] == BASE);
   assign is_inta = (bst == BST_INTA);
   // One write per rising strobe; a held-high cruclk is ignored after the first cycle
   assign wr_stb  = cruclk & ~cruclk_d & sel;
   assign active  = pend_q & mask_q;
   assign flag    = flag_q;

   // Per-source set and clear requests; the caller gives set priority over clear
   always_comb begin
      pend_set = '0;
      pend_clr = '0;
      for (int k = 0; k < NSRC; k++) begin
         pend_set[k] = (EDGE_MASK[k] ? (src[k] & ~src_d[k]) : src[k])
                     | (wr_stb & (cru_bit == 4'(PEND_OFS + k)) & cruout);
         pend_clr[k] = (is_inta & (cab[5:2] == (LVL0 + 4'(k))))
                     | (wr_stb & (cru_bit == 4'(PEND_OFS + k)) & ~cruout);
      end
   end

   // Strobe/source history, mask, pending latches and flag bits
   always_ff @(posedge clk) begin
      if (reset) begin
         cruclk_d <= 1'b0;
         src_d    <= '0;
         mask_q   <= '0;
         pend_q   <= '0;
         flag_q   <= '0;
      end else begin
         cruclk_d <= cruclk;
         src_d    <= src;
         pend_q   <= (pend_q & ~pend_clr) | pend_set;
         for (int k = 0; k < NSRC; k++) begin
            if (wr_stb && (cru_bit == 4'(MASK_OFS + k))) mask_q[k] <= cruout;
         end
         if (wr_stb && !MAP_BITS[cru_bit]) flag_q[cru_bit] <= cruout;
      end
   end

   prio_enc #(
      .N     (NSRC)
   ) u_prio_enc (
      .req   (active),
      .valid (act_vld),
      .idx   (act_idx)
   );

   // Registered request and level code; ic keeps the last winner when idle
   always_ff @(posedge clk) begin
      if (reset) begin
         int_req <= 1'b0;
         ic      <= LVL0;
      end else begin
         int_req <= act_vld;
         if (act_vld) ic <= LVL0 + {1'b0, act_idx};
      end
   end

   // CRU read mux: mapped mask/pending bits override the flag bit; 1 outside the window
   always_comb begin
      rd_bit = flag_q[cru_bit];
      for (int k = 0; k < NSRC; k++) begin
         if (cru_bit == 4'(MASK_OFS + k)) rd_bit = mask_q[k];
         if (cru_bit == 4'(PEND_OFS + k)) rd_bit = pend_q[k];
      end
      cruin = sel ? rd_bit : 1'b1;
   end

endmodule

// File: tb/tb_cru_irq_ctrl.sv
// Bench for cru_irq_ctrl: two instances (EDGE_MASK 01 and 03) on shared inputs,
// directed scenarios followed by random traffic, all checked against a
// rule-level reference model every cycle.
module tb_cru_irq_ctrl;

   localparam int          NSRC = 2;
   localparam logic [10:0] BASE = 11'h0F7;
   localparam logic [3:0]  LVL0 = 4'd1;

   logic        clk;
   logic        reset;
   logic [15:0] cab;
   logic [3:0]  bst;
   logic        cruclk;
   logic        cruout;
   logic [NSRC-1:0] src;

   logic        sel_a, cruin_a, int_req_a;
   logic [3:0]  ic_a;
   logic [15:0] flag_a;
   logic        sel_b, cruin_b, int_req_b;
   logic [3:0]  ic_b;
   logic [15:0] flag_b;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state, index 0 = instance a, 1 = instance b
   logic [7:0]      m_edge [2];
   logic [NSRC-1:0] m_mask [2];
   logic [NSRC-1:0] m_pend [2];
   logic [15:0]     m_flag [2];
   logic            m_int  [2];
   logic [3:0]      m_ic   [2];
   logic            m_prev_clk;
   logic [NSRC-1:0] m_prev_src;

   cru_irq_ctrl #(.NSRC(NSRC), .BASE(BASE), .LVL0(LVL0), .EDGE_MASK(8'h01)) dut_a (
      .clk(clk), .reset(reset), .cab(cab), .bst(bst), .cruclk(cruclk), .cruout(cruout),
      .src(src), .sel(sel_a), .cruin(cruin_a), .int_req(int_req_a), .ic(ic_a), .flag(flag_a));

   cru_irq_ctrl #(.NSRC(NSRC), .BASE(BASE), .LVL0(LVL0), .EDGE_MASK(8'h03)) dut_b (
      .clk(clk), .reset(reset), .cab(cab), .bst(bst), .cruclk(cruclk), .cruout(cruout),
      .src(src), .sel(sel_b), .cruin(cruin_b), .int_req(int_req_b), .ic(ic_b), .flag(flag_b));

   initial clk = 1'b0;
   always #20 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic in_window();
      return cab[15:5] == BASE;
   endfunction

   // Expected CRU read value for instance i from the bit map rules
   function automatic logic exp_cruin(input int i);
      int b;
      if (!in_window()) return 1'b1;
      b = int'(cab[4:1]);
      if (b < NSRC) return m_mask[i][b];
      if (b >= 8 && b < 8 + NSRC) return m_pend[i][b - 8];
      return m_flag[i][b];
   endfunction

   // Advance the model by one clock using the inputs present at the edge
   task automatic model_step();
      logic wr;
      int   b;
      logic set, clr;
      if (reset) begin
         for (int i = 0; i < 2; i++) begin
            m_mask[i] = '0; m_pend[i] = '0; m_flag[i] = '0;
            m_int[i]  = 1'b0; m_ic[i] = LVL0;
         end
         m_prev_clk = 1'b0;
         m_prev_src = '0;
         return;
      end
      wr = cruclk && !m_prev_clk && in_window();
      b  = int'(cab[4:1]);
      for (int i = 0; i < 2; i++) begin
         // arbitration sees the pending/mask state from before this edge
         m_int[i] = 1'b0;
         for (int k = NSRC - 1; k >= 0; k--) begin
            if (m_pend[i][k] && m_mask[i][k]) begin
               m_int[i] = 1'b1;
               m_ic[i]  = LVL0 + 4'(k);
            end
         end
         for (int k = 0; k < NSRC; k++) begin
            if (m_edge[i][k]) set = src[k] && !m_prev_src[k];
            else              set = src[k];
            set = set || (wr && b == 8 + k && cruout);
            clr = (bst == 4'b0101 && int'(cab[5:2]) == int'(LVL0) + k) ||
                  (wr && b == 8 + k && !cruout);
            if (set)      m_pend[i][k] = 1'b1;
            else if (clr) m_pend[i][k] = 1'b0;
         end
         if (wr) begin
            if (b < NSRC) m_mask[i][b] = cruout;
            else if (!(b >= 8 && b < 8 + NSRC)) m_flag[i][b] = cruout;
         end
      end
      m_prev_clk = cruclk;
      m_prev_src = src;
   endtask

   task automatic check_all();
      check("a_sel",   16'(sel_a),     16'(in_window()));
      check("a_cruin", 16'(cruin_a),   16'(exp_cruin(0)));
      check("a_int",   16'(int_req_a), 16'(m_int[0]));
      check("a_ic",    16'(ic_a),      16'(m_ic[0]));
      check("a_flag",  flag_a,         m_flag[0]);
      check("b_sel",   16'(sel_b),     16'(in_window()));
      check("b_cruin", 16'(cruin_b),   16'(exp_cruin(1)));
      check("b_int",   16'(int_req_b), 16'(m_int[1]));
      check("b_ic",    16'(ic_b),      16'(m_ic[1]));
      check("b_flag",  flag_b,         m_flag[1]);
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic cru_write(input logic [15:0] addr, input logic val);
      cab = addr; cruout = val; cruclk = 1'b1;
      tick();
      cruclk = 1'b0;
      tick();
   endtask

   initial begin
      m_edge[0] = 8'h01;
      m_edge[1] = 8'h03;
      m_prev_clk = 1'b0;
      m_prev_src = '0;
      for (int i = 0; i < 2; i++) begin
         m_mask[i] = '0; m_pend[i] = '0; m_flag[i] = '0; m_int[i] = 1'b0; m_ic[i] = LVL0;
      end
      reset = 1'b1; cab = 16'h0000; bst = 4'h0; cruclk = 1'b0; cruout = 1'b0; src = '0;
      tick();
      tick();

      // reset state
      check("rst_int",   16'(int_req_a), 16'd0);
      check("rst_ic",    16'(ic_a),      16'd1);
      check("rst_flag",  flag_a,         16'h0000);
      check("rst_cruin", 16'(cruin_a),   16'd1);
      check("rst_sel",   16'(sel_a),     16'd0);
      reset = 1'b0;
      cab = 16'h1EE0; #1;
      check("rd_1ee0",   16'(cruin_a),   16'd0);
      tick();

      // mask0, one-cycle pulse on src0, latency, then INTA clears it
      cru_write(16'h1EE0, 1'b1);
      cab = 16'h0000;
      src = 2'b01;
      tick();
      src = 2'b00;
      cab = 16'h1EF0; #1;
      check("lat_pend_n1", 16'(cruin_a),   16'd1);
      check("lat_int_n1",  16'(int_req_a), 16'd0);
      tick();
      check("lat_int_n2",  16'(int_req_a), 16'd1);
      check("lat_ic_n2",   16'(ic_a),      16'd1);
      bst = 4'b0101; cab = 16'h0004;
      tick();
      bst = 4'h0; cab = 16'h0000;
      tick();
      check("ack_int_off", 16'(int_req_a), 16'd0);

      // both edge sources rise together on instance b; ack level 1 moves ic to 2
      cru_write(16'h1EE2, 1'b1);
      cab = 16'h0000;
      src = 2'b11;
      tick();
      tick();
      check("both_ic",  16'(ic_b),      16'd1);
      check("both_int", 16'(int_req_b), 16'd1);
      bst = 4'b0101; cab = 16'h0004;
      tick();
      bst = 4'h0; cab = 16'h0000;
      tick();
      check("ack1_ic",  16'(ic_b),      16'd2);
      check("ack1_int", 16'(int_req_b), 16'd1);

      // level source1 held high on instance a resists a software clear
      cru_write(16'h1EF2, 1'b0);
      #1;
      check("lvl_hold", 16'(cruin_a), 16'd1);
      src = 2'b00;
      tick();
      cru_write(16'h1EF2, 1'b0);
      #1;
      check("lvl_clr",  16'(cruin_a), 16'd0);

      // edge on src0 coincident with INTA for level 1: set wins
      src = 2'b01; bst = 4'b0101; cab = 16'h0004;
      tick();
      src = 2'b00; bst = 4'h0; cab = 16'h1EF0; #1;
      check("set_beats_ack", 16'(cruin_a), 16'd1);
      tick();

      // held strobe on flag bit 5: only the first value is stored
      for (int pass = 0; pass < 2; pass++) begin
         cab = 16'h1EEA; cruout = (pass == 0); cruclk = 1'b1;
         tick();
         for (int c = 0; c < 4; c++) begin
            cruout = ~cruout;
            tick();
         end
         cruclk = 1'b0;
         tick();
         check("hold_rd",    16'(cruin_a),   16'(pass == 0));
         check("hold_flag5", 16'(flag_a[5]), 16'(pass == 0));
      end

      // random traffic, checked against the model every cycle
      for (int n = 0; n < 4000; n++) begin
         reset = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 2) == 0) cruclk = ~cruclk;
         cruout = 1'($urandom);
         case ($urandom_range(0, 3))
            0, 1:    cab = {BASE, 5'($urandom)};
            2:       cab = {10'h000, 4'($urandom_range(0, 3)), 2'b00};
            default: cab = 16'($urandom);
         endcase
         bst = ($urandom_range(0, 3) == 0) ? 4'b0101 : 4'($urandom_range(6, 15));
         if ($urandom_range(0, 2) == 0) src = 2'($urandom);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
